// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen_pkg
//  Description : Shared constants, state encoding and helpers for the IF-stage
//                fetch-address generator and its pending-redirect register.
//  Ports       : (package, none)
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pc_gen_pkg;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

   localparam logic Branch      = 1'b1;
   localparam logic NotBranch   = 1'b0;
   localparam logic Stop        = 1'b1;
   localparam logic NoStop      = 1'b0;
   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;
   // Level of rst that holds the block in reset (active-low).
   localparam logic RstEnable   = 1'b0;

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } pc_state_e;

   // Bytes covered by one fetch group of fetch_w 32-bit instructions.
   function automatic int group_bytes(input int fetch_w);
      return fetch_w * 4;
   endfunction

endpackage : fetch_pc_gen_pkg
`default_nettype wire

// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen_if
//  Description : Instruction-memory fetch bus between the PC generator
//                (master) and the instruction SRAM / cache (slave).
//  Signals     : if_req      - fetch request
//                if_ack      - memory accepted pc this cycle
//                pc          - fetch address
//                ce          - memory chip enable
//                slot_valid  - valid instruction slots in the fetch group
//                pc_misalign - fetch address not word aligned
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_gen_if #(
   parameter int ADDR_W  = 32,
   parameter int FETCH_W = 1
) ();

   logic               if_req;
   logic               if_ack;
   logic [ADDR_W-1:0]  pc;
   logic               ce;
   logic [FETCH_W-1:0] slot_valid;
   logic               pc_misalign;

   modport master (
      output if_req,
      output pc,
      output ce,
      output slot_valid,
      output pc_misalign,
      input  if_ack
   );

   modport slave (
      input  if_req,
      input  pc,
      input  ce,
      input  slot_valid,
      input  pc_misalign,
      output if_ack
   );

endinterface : fetch_pc_gen_if
`default_nettype wire

// File: rtl/fetch_redirect_hold.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_redirect_hold
//  Description : Holds one resolved branch target that arrived while IF could
//                not advance, until the PC generator applies it.
//  Ports       : clk, rst        - clock, async active-low reset
//                capture_i       - load target_i and mark valid
//                apply_i         - held target consumed, clear valid
//                flush_i         - CP0 redirect, discard held target
//                target_i        - branch target to capture
//                valid_o         - a held target is waiting
//                target_o        - the held target
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_redirect_hold
   import fetch_pc_gen_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture_i,
   input  logic              apply_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] target_o
);

   logic              valid_q,  valid_d;
   logic [ADDR_W-1:0] target_q, target_d;

   // Flush beats capture; a newer capture overwrites an older held target.
   always_comb begin
      valid_d  = valid_q;
      target_d = target_q;
      if (flush_i) begin
         valid_d = NotBranch;
      end else if (capture_i) begin
         valid_d  = Branch;
         target_d = target_i;
      end else if (apply_i) begin
         valid_d = NotBranch;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         valid_q  <= NotBranch;
         target_q <= '0;
      end else begin
         valid_q  <= valid_d;
         target_q <= target_d;
      end
   end

   assign valid_o  = valid_q;
   assign target_o = target_q;

endmodule : fetch_redirect_hold
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_gen
//  Description : IF-stage fetch-address generator. Issues the fetch address,
//                chip enable and slot mask, steps by whole fetch groups, and
//                never drops a branch that resolves while IF is stalled.
//  Ports       : clk, rst                  - clock, async active-low reset
//                stall                     - stall vector, bit 0 freezes PC
//                branch_flag_i / _target_  - taken branch and its target
//                cp0_branch_flag / _addr   - exception / ERET redirect
//                imem (master)             - fetch bus to instruction memory
//                redirect_pending          - a held branch is waiting
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
   import fetch_pc_gen_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEFAULT),
   parameter int                FETCH_W      = 1,
   parameter int                STALL_W      = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               branch_flag_i,
   input  logic [ADDR_W-1:0]  branch_target_address_i,
   input  logic               cp0_branch_flag,
   input  logic [ADDR_W-1:0]  cp0_branch_addr,
   fetch_pc_gen_if.master     imem,
   output logic               redirect_pending
);

   localparam int                GROUP_BYTES = group_bytes(FETCH_W);
   localparam int                OFF_W       = $clog2(GROUP_BYTES);
   localparam logic [ADDR_W-1:0] GROUP_MASK  = ADDR_W'(GROUP_BYTES - 1);
   localparam logic [ADDR_W-1:0] GROUP_STEP  = ADDR_W'(GROUP_BYTES);

   pc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] pc_q,    pc_d;

   logic              run;
   logic              adv;
   logic              ce;
   logic              hold_valid;
   logic [ADDR_W-1:0] hold_target;
   logic              hold_capture;
   logic              hold_apply;
   logic              hold_flush;
   logic              unused_stall;

   // Only stall[0] concerns IF; the rest of the vector belongs to later stages.
   assign unused_stall = ^stall;

   assign run = (state_q == RUN);
   assign adv = run && imem.if_ack && (stall[0] != Stop);
   assign ce  = run ? ChipEnable : ChipDisable;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      hold_apply = 1'b0;
      hold_flush = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (cp0_branch_flag == Branch) begin
               // CP0 wins even when stalled or unacknowledged.
               pc_d       = cp0_branch_addr;
               hold_flush = 1'b1;
            end else if (hold_valid && adv) begin
               pc_d       = hold_target;
               hold_apply = 1'b1;
            end else if ((branch_flag_i == Branch) && adv) begin
               pc_d = branch_target_address_i;
            end else if (adv) begin
               pc_d = (pc_q & ~GROUP_MASK) + GROUP_STEP;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
      // A branch that cannot be taken this edge is parked unless CP0 overrides.
      hold_capture = (branch_flag_i == Branch) && !adv && !hold_flush;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_redirect_hold #(
      .ADDR_W (ADDR_W)
   ) u_redirect_hold (
      .clk       (clk),
      .rst       (rst),
      .capture_i (hold_capture),
      .apply_i   (hold_apply),
      .flush_i   (hold_flush),
      .target_i  (branch_target_address_i),
      .valid_o   (hold_valid),
      .target_o  (hold_target)
   );

   // Slot i is valid when it lies at or beyond the pc's position in its group.
   generate
      if (FETCH_W == 1) begin : g_single_slot
         assign imem.slot_valid = ce;
      end else begin : g_group_slots
         logic [OFF_W-3:0]   slot_idx;
         logic [FETCH_W-1:0] slot_mask;
         assign slot_idx = pc_q[OFF_W-1:2];
         always_comb begin
            slot_mask = '0;
            for (int i = 0; i < FETCH_W; i++) begin
               slot_mask[i] = ce && (i >= int'(slot_idx));
            end
         end
         assign imem.slot_valid = slot_mask;
      end
   endgenerate

   assign imem.if_req      = ce;
   assign imem.ce          = ce;
   assign imem.pc          = pc_q;
   assign imem.pc_misalign = ce && (pc_q[1:0] != 2'b00);
   assign redirect_pending = hold_valid;

endmodule : fetch_pc_gen
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_pc_gen
//  Description : Self-checking bench for fetch_pc_gen with FETCH_W=1 and
//                FETCH_W=4 instances driven by shared stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_flag;
   logic [31:0] branch_target;
   logic        cp0_flag;
   logic [31:0] cp0_addr;
   logic        ack;
   logic        pend1, pend4;

   int n_vec;
   int n_err;

   typedef struct {
      string       tag;
      int          dut;
      logic [31:0] pc;
      logic        pend;
      logic [3:0]  slot;
      logic        mis;
   } exp_t;

   exp_t sb[$];

   fetch_pc_gen_if #(.ADDR_W(32), .FETCH_W(1)) bus1 ();
   fetch_pc_gen_if #(.ADDR_W(32), .FETCH_W(4)) bus4 ();

   assign bus1.if_ack = ack;
   assign bus4.if_ack = ack;

   fetch_pc_gen #(
      .ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000), .FETCH_W(1), .STALL_W(6)
   ) dut1 (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .branch_flag_i           (branch_flag),
      .branch_target_address_i (branch_target),
      .cp0_branch_flag         (cp0_flag),
      .cp0_branch_addr         (cp0_addr),
      .imem                    (bus1.master),
      .redirect_pending        (pend1)
   );

   fetch_pc_gen #(
      .ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000), .FETCH_W(4), .STALL_W(6)
   ) dut4 (
      .clk                     (clk),
      .rst                     (rst),
      .stall                   (stall),
      .branch_flag_i           (branch_flag),
      .branch_target_address_i (branch_target),
      .cp0_branch_flag         (cp0_flag),
      .cp0_branch_addr         (cp0_addr),
      .imem                    (bus4.master),
      .redirect_pending        (pend4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_edge(input string tag, input int dut, input logic [31:0] pc,
                              input logic pend, input logic [3:0] slot, input logic mis);
      exp_t e;
      e.tag  = tag;
      e.dut  = dut;
      e.pc   = pc;
      e.pend = pend;
      e.slot = slot;
      e.mis  = mis;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Scoreboard: everything queued before an edge is checked just after it.
   always @(posedge clk) begin
      exp_t e;
      #1;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         if (e.dut == 1) begin
            check_val({e.tag, "/pc"},   bus1.pc, e.pc);
            check_val({e.tag, "/ce"},   32'(bus1.ce), 32'd1);
            check_val({e.tag, "/req"},  32'(bus1.if_req), 32'd1);
            check_val({e.tag, "/pend"}, 32'(pend1), 32'(e.pend));
            check_val({e.tag, "/slot"}, 32'(bus1.slot_valid), 32'(e.slot));
            check_val({e.tag, "/mis"},  32'(bus1.pc_misalign), 32'(e.mis));
         end else begin
            check_val({e.tag, "/pc4"},   bus4.pc, e.pc);
            check_val({e.tag, "/ce4"},   32'(bus4.ce), 32'd1);
            check_val({e.tag, "/pend4"}, 32'(pend4), 32'(e.pend));
            check_val({e.tag, "/slot4"}, 32'(bus4.slot_valid), 32'(e.slot));
            check_val({e.tag, "/mis4"},  32'(bus4.pc_misalign), 32'(e.mis));
         end
      end
   end

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst           = 1'b0;
      stall         = '0;
      branch_flag   = 1'b0;
      branch_target = '0;
      cp0_flag      = 1'b0;
      cp0_addr      = '0;
      ack           = 1'b1;

      repeat (2) @(negedge clk);
      check_val("rst/pc",   bus1.pc, 32'hBFC0_0000);
      check_val("rst/ce",   32'(bus1.ce), 32'd0);
      check_val("rst/req",  32'(bus1.if_req), 32'd0);
      check_val("rst/slot", 32'(bus1.slot_valid), 32'd0);
      check_val("rst/pend", 32'(pend1), 32'd0);
      check_val("rst/mis",  32'(bus1.pc_misalign), 32'd0);
      check_val("rst/pc4",  bus4.pc, 32'hBFC0_0000);
      check_val("rst/slot4", 32'(bus4.slot_valid), 32'd0);

      // Reset release: BOOT for one edge, then sequential fetch.
      rst = 1'b1;
      #1;
      check_val("boot/ce", 32'(bus1.ce), 32'd0);
      expect_edge("t1_boot", 1, 32'hBFC0_0000, 1'b0, 4'b0001, 1'b0);
      expect_edge("t1_boot", 4, 32'hBFC0_0000, 1'b0, 4'b1111, 1'b0);
      tick();
      expect_edge("t1_s1", 1, 32'hBFC0_0004, 1'b0, 4'b0001, 1'b0);
      expect_edge("t1_s1", 4, 32'hBFC0_0010, 1'b0, 4'b1111, 1'b0);
      tick();
      expect_edge("t1_s2", 1, 32'hBFC0_0008, 1'b0, 4'b0001, 1'b0);
      tick();
      expect_edge("t1_s3", 1, 32'hBFC0_000C, 1'b0, 4'b0001, 1'b0);
      tick();
      expect_edge("t1_s4", 1, 32'hBFC0_0010, 1'b0, 4'b0001, 1'b0);
      tick();

      // No acknowledge: pc holds while the request stays up.
      ack = 1'b0;
      expect_edge("t6_hold", 1, 32'hBFC0_0010, 1'b0, 4'b0001, 1'b0);
      tick();
      expect_edge("t6_hold", 1, 32'hBFC0_0010, 1'b0, 4'b0001, 1'b0);
      tick();
      ack = 1'b1;
      expect_edge("t6_ack", 1, 32'hBFC0_0014, 1'b0, 4'b0001, 1'b0);
      tick();

      // Branch during stall is held, then applied on the first advance.
      stall[0] = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_1000;
      expect_edge("t2_cap", 1, 32'hBFC0_0014, 1'b1, 4'b0001, 1'b0);
      tick();
      branch_flag = 1'b0;
      expect_edge("t2_frz", 1, 32'hBFC0_0014, 1'b1, 4'b0001, 1'b0);
      tick();
      expect_edge("t2_frz", 1, 32'hBFC0_0014, 1'b1, 4'b0001, 1'b0);
      tick();
      stall[0] = 1'b0;
      expect_edge("t2_apply", 1, 32'h8000_1000, 1'b0, 4'b0001, 1'b0);
      expect_edge("t2_apply", 4, 32'h8000_1000, 1'b0, 4'b1111, 1'b0);
      tick();
      expect_edge("t2_seq", 1, 32'h8000_1004, 1'b0, 4'b0001, 1'b0);
      tick();

      // Youngest held branch wins.
      stall[0] = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_2000;
      expect_edge("ow_a", 1, 32'h8000_1004, 1'b1, 4'b0001, 1'b0);
      tick();
      branch_target = 32'h8000_3000;
      expect_edge("ow_b", 1, 32'h8000_1004, 1'b1, 4'b0001, 1'b0);
      tick();
      branch_flag = 1'b0; stall[0] = 1'b0;
      expect_edge("ow_apply", 1, 32'h8000_3000, 1'b0, 4'b0001, 1'b0);
      tick();

      // CP0 redirect overrides a held branch, even stalled and unacked.
      stall[0] = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_1000;
      expect_edge("t3_cap", 1, 32'h8000_3000, 1'b1, 4'b0001, 1'b0);
      tick();
      branch_flag = 1'b0; cp0_flag = 1'b1; cp0_addr = 32'h8000_0180; ack = 1'b0;
      expect_edge("t3_cp0", 1, 32'h8000_0180, 1'b0, 4'b0001, 1'b0);
      expect_edge("t3_cp0", 4, 32'h8000_0180, 1'b0, 4'b1111, 1'b0);
      tick();
      cp0_flag = 1'b0; ack = 1'b1; stall[0] = 1'b0;
      expect_edge("t3_seq", 1, 32'h8000_0184, 1'b0, 4'b0001, 1'b0);
      expect_edge("t3_seq", 4, 32'h8000_0190, 1'b0, 4'b1111, 1'b0);
      tick();
      expect_edge("t3_seq2", 1, 32'h8000_0188, 1'b0, 4'b0001, 1'b0);
      tick();

      // Fetch group slot masks and group-aligned stepping.
      branch_flag = 1'b1; branch_target = 32'h8000_0008;
      expect_edge("t4_br", 1, 32'h8000_0008, 1'b0, 4'b0001, 1'b0);
      expect_edge("t4_br", 4, 32'h8000_0008, 1'b0, 4'b1100, 1'b0);
      tick();
      branch_flag = 1'b0;
      expect_edge("t4_seq", 1, 32'h8000_000C, 1'b0, 4'b0001, 1'b0);
      expect_edge("t4_seq", 4, 32'h8000_0010, 1'b0, 4'b1111, 1'b0);
      tick();

      // Address wrap and misaligned targets.
      branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
      expect_edge("t5_top", 1, 32'hFFFF_FFFC, 1'b0, 4'b0001, 1'b0);
      expect_edge("t5_top", 4, 32'hFFFF_FFFC, 1'b0, 4'b1000, 1'b0);
      tick();
      branch_flag = 1'b0;
      expect_edge("t5_wrap", 1, 32'h0000_0000, 1'b0, 4'b0001, 1'b0);
      expect_edge("t5_wrap", 4, 32'h0000_0000, 1'b0, 4'b1111, 1'b0);
      tick();
      branch_flag = 1'b1; branch_target = 32'h8000_0002;
      expect_edge("t5_mis", 1, 32'h8000_0002, 1'b0, 4'b0001, 1'b1);
      expect_edge("t5_mis", 4, 32'h8000_0002, 1'b0, 4'b1111, 1'b1);
      tick();
      branch_flag = 1'b0;
      expect_edge("t5_realign", 1, 32'h8000_0004, 1'b0, 4'b0001, 1'b0);
      expect_edge("t5_realign", 4, 32'h8000_0010, 1'b0, 4'b1111, 1'b0);
      tick();

      // Reset mid-operation drops a held branch.
      stall[0] = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_5000;
      expect_edge("rm_cap", 1, 32'h8000_0004, 1'b1, 4'b0001, 1'b0);
      tick();
      branch_flag = 1'b0;
      rst = 1'b0;
      #1;
      check_val("rm_rst/pc",   bus1.pc, 32'hBFC0_0000);
      check_val("rm_rst/pend", 32'(pend1), 32'd0);
      check_val("rm_rst/ce",   32'(bus1.ce), 32'd0);
      tick();
      stall[0] = 1'b0;
      rst = 1'b1;
      #1;
      check_val("rm_boot/ce", 32'(bus1.ce), 32'd0);
      expect_edge("rm_boot", 1, 32'hBFC0_0000, 1'b0, 4'b0001, 1'b0);
      tick();
      expect_edge("rm_seq", 1, 32'hBFC0_0004, 1'b0, 4'b0001, 1'b0);
      expect_edge("rm_seq", 4, 32'hBFC0_0010, 1'b0, 4'b1111, 1'b0);
      tick();
      tick();

      check_val("sb_drain", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fetch_pc_gen
`default_nettype wire
